// File: rtl/ccode_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ccode_pkg : condition encodings, flag bit positions and condition evaluator
// Revision  : 1.0
// ---------------------------------------------------------------------------
package ccode_pkg;

  localparam logic [2:0] CC_NE = 3'b000;
  localparam logic [2:0] CC_EQ = 3'b001;
  localparam logic [2:0] CC_GT = 3'b010;
  localparam logic [2:0] CC_LT = 3'b011;
  localparam logic [2:0] CC_GE = 3'b100;
  localparam logic [2:0] CC_LE = 3'b101;
  localparam logic [2:0] CC_OV = 3'b110;
  localparam logic [2:0] CC_UN = 3'b111;

  localparam int FLG_N = 2;
  localparam int FLG_V = 1;
  localparam int FLG_Z = 0;

  function automatic logic cc_eval(input logic [2:0] cond, input logic [2:0] nvz);
    logic n, v, z, res;
    n   = nvz[FLG_N];
    v   = nvz[FLG_V];
    z   = nvz[FLG_Z];
    res = 1'b0;
    case (cond)
      CC_NE:   res = ~z;
      CC_EQ:   res = z;
      CC_GT:   res = ~z & ~n;
      CC_LT:   res = n;
      CC_GE:   res = z | (~n & ~z);
      CC_LE:   res = n | z;
      CC_OV:   res = v;
      default: res = 1'b1;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cc_flag_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cc_flag_bank : one N/V/Z flag set with masked update and sticky overflow
// Revision     : 1.0
// ---------------------------------------------------------------------------
module cc_flag_bank
  import ccode_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_mask,
  input  logic [2:0] wr_flags,
  input  logic       clr_sticky,
  output logic [2:0] flags,
  output logic       sticky
);

  always_ff @(posedge clk) begin
    if (rst) begin
      flags  <= 3'b000;
      sticky <= 1'b0;
    end else begin
      if (wr_en) begin
        flags <= (flags & ~wr_mask) | (wr_flags & wr_mask);
      end
      // A new overflow outranks a same-cycle clear.
      if (wr_en && wr_mask[FLG_V] && wr_flags[FLG_V]) begin
        sticky <= 1'b1;
      end else if (clr_sticky) begin
        sticky <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ccode_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ccode_unit : banked condition-code flags with branch-condition evaluation
// Revision   : 1.0
// ---------------------------------------------------------------------------
module ccode_unit
  import ccode_pkg::*;
#(
  parameter  int DATA_W    = 16,
  parameter  int NUM_BANKS = 2,
  parameter  int BYPASS    = 1,
  parameter  int REG_OUT   = 1,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [BANK_W-1:0]    wr_bank,
  input  logic [2:0]           wr_mask,
  input  logic [DATA_W-1:0]    alu_out,
  input  logic                 alu_ovfl,
  input  logic                 rd_en,
  input  logic [BANK_W-1:0]    rd_bank,
  input  logic [2:0]           cond,
  input  logic [NUM_BANKS-1:0] clr_sticky,
  output logic                 cond_valid,
  output logic                 cond_true,
  output logic [2:0]           rd_flags,
  output logic [NUM_BANKS-1:0] sticky_v
);

  logic [2:0]           derived;
  logic [2:0]           bank_flags [NUM_BANKS];
  logic [NUM_BANKS-1:0] bank_wr;
  logic [2:0]           stored;
  logic                 bypass_hit;
  logic [2:0]           eff_flags;
  logic                 eval_true;

  always_comb begin
    derived        = 3'b000;
    derived[FLG_N] = alu_out[DATA_W-1];
    derived[FLG_V] = alu_ovfl;
    derived[FLG_Z] = (alu_out == '0);
  end

  // Out-of-range write banks match no instance and are therefore dropped.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_wr[b] = wr_en && (wr_bank == BANK_W'(b));

    cc_flag_bank u_bank (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (bank_wr[b]),
      .wr_mask    (wr_mask),
      .wr_flags   (derived),
      .clr_sticky (clr_sticky[b]),
      .flags      (bank_flags[b]),
      .sticky     (sticky_v[b])
    );
  end

  always_comb begin
    stored = 3'b000;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_bank == BANK_W'(b)) begin
        stored = bank_flags[b];
      end
    end
  end

  assign bypass_hit = (BYPASS != 0) && rd_en && (|bank_wr) && (rd_bank == wr_bank);
  assign eff_flags  = bypass_hit ? ((stored & ~wr_mask) | (derived & wr_mask)) : stored;
  assign eval_true  = cc_eval(cond, eff_flags);

  if (REG_OUT != 0) begin : g_reg_out
    always_ff @(posedge clk) begin
      if (rst) begin
        cond_valid <= 1'b0;
        cond_true  <= 1'b0;
        rd_flags   <= 3'b000;
      end else begin
        cond_valid <= rd_en;
        cond_true  <= rd_en & eval_true;
        if (rd_en) begin
          rd_flags <= eff_flags;
        end
      end
    end
  end else begin : g_comb_out
    assign cond_valid = rd_en;
    assign cond_true  = rd_en & eval_true;
    assign rd_flags   = eff_flags;
  end

endmodule
`default_nettype wire
